aq_vpu_group1_pipe_ctrl: RTL and testbench
==========================================

// Module: aq_vpu_group1_pipe_ctrl
// PURPOSE
//   Issue-side pipeline controller for VPU group 1 (falu/fadd and siblings). Accepts issued
//   instructions from the IDU and tracks them through four registered stages, ex1..ex4.
//   Drives the per-stage sel/eu_sel and stall signals that the group-1 execution-unit ctrl
//   blocks use to form their pipedown and gated-clock enables.
//   Merges ex4 writeback backpressure and the ex1 denormal stall into the stall chain.
//   Provides the issue backpressure signal to the IDU.
// PARAMETERS
//   EU_SEL_WIDTH  10  width of the eu_sel one-hot/field vector; carried opaquely, never decoded
// PORTS
//   forever_cpuclk                in   1   clock
//   cpurst_b                      in   1   async active-low reset
//   idu_vpu_ex1_inst_vld          in   1   issue request this cycle
//   idu_vpu_ex1_eu_sel            in   10  eu_sel of the issued instruction
//   rtu_yy_xx_flush               in   1   pipeline flush; kills ex1..ex3
//   vpu_ex4_wb_stall              in   1   writeback port busy; ex4 cannot retire
//   vfalu_vpu_ex1_denormal_stall  in   1   ex1 needs an extra cycle
//   vpu_idu_ex1_stall             out  1   issue backpressure; issue not accepted
//   vpu_group_1_xx_ex{1,2,3,4}_sel      out  1   stage N holds a valid instruction
//   vpu_group_1_xx_ex{1,2,3,4}_eu_sel   out  10  eu_sel of the stage N instruction
//   vpu_group_1_xx_ex{2,3,4}_stall      out  1   stage N holds this cycle
//   vpu_rtu_ex4_wb_vld            out  1   ex4 retires this cycle; one pulse per instruction
// BEHAVIOUR
//   Reset: all exN valid = 0; all eu_sel = 0; all outputs 0.
//   Reset is taken immediately, mid-operation included; in-flight instructions are dropped.
//   Stall chain, combinational on the current valids:
//     ex4_stall = ex4_vld & vpu_ex4_wb_stall
//     ex3_stall = ex3_vld & ex4_stall
//     ex2_stall = ex2_vld & ex3_stall
//     ex1_hold  = ex1_vld & (ex2_stall | vfalu_vpu_ex1_denormal_stall)
//   Backpressure: vpu_idu_ex1_stall = ex1_hold | rtu_yy_xx_flush.
//   Issue acceptance: an issue is accepted iff idu_vpu_ex1_inst_vld & !vpu_idu_ex1_stall.
//   Stage update each cycle, evaluated from ex4 down to ex1:
//     - A stage that stalls or holds keeps its valid bit and eu_sel.
//     - Otherwise stage N+1 loads the valid bit of stage N, gated by !ex(N)_hold.
//     - ex1 denormal hold sends a bubble into ex2.
//     - ex1 loads the accepted issue, or a bubble when no issue is accepted.
//   ex4 is not stalled:
//     - ex4 retires; vpu_rtu_ex4_wb_vld = ex4_vld & !vpu_ex4_wb_stall.
//     - ex4 then loads from ex3.
//   eu_sel registers:
//     - Update only when the stage loads a valid instruction.
//     - Otherwise keep their value (stale when sel = 0) to save power.
//     - Consumers must qualify eu_sel with sel.
//   Latency: an instruction issued in cycle T appears as ex1_sel in T+1 and ex4_sel in T+4.
//   With no stalls, retire pulses in T+4.
//   Throughput: one instruction per cycle.
//   Order is strictly in order; instructions are never duplicated or dropped except by flush.
//   Flush (1 cycle):
//     - Next cycle, ex1..ex3 valid = 0.
//     - Issue is blocked in the flush cycle.
//     - ex4 keeps its content and stall behaviour; it is committed.
//     - ex3 does not advance into ex4 in the flush cycle.
//     - Flush while ex3_stall: ex3 is cleared, and ex3_stall drops in the next cycle.
//   Simultaneous flush and wb_stall release: ex4 retires; ex4 then becomes empty.
//   Denormal stall with ex1 empty: no effect; issue is accepted normally.
//   No ex1 instruction stays stuck while ex2 is empty: ex1 advances whenever !ex1_hold.
//   ifu_vpu_warm_up does not affect this block; consumers OR it into their pipedowns.
// TESTING
//   1. Single issue, eu_sel=10'h041 at T0, no stalls -> ex1_sel@T1 .. ex4_sel@T4,
//      eu_sel=10'h041 at each stage, wb_vld pulse @T4 only.
//   2. Issue 4 back-to-back (A,B,C,D); wb_stall high T4..T5
//      -> ex4=A held, ex4/3/2_stall=1 T4..T5, idu stall T4..T5, A retires T6, D retires T9.
//   3. denormal_stall high for 1 cycle with ex1=A, B issuing
//      -> B rejected that cycle, ex2 bubble, A in ex2 next cycle, B accepted one cycle later.
//   4. Flush with ex1..ex4 all full and wb_stall=1
//      -> next cycle ex1..ex3 sel=0, ex4 unchanged; release wb_stall -> single wb_vld.
//   5. Assert cpurst_b low mid-stream -> all sel/stall/wb_vld=0 immediately,
//      eu_sel=0; first issue after release behaves as in test 1.
//   6. Random issue/stall/flush soak against a reference queue model
//      -> in-order retire, no loss or duplication, sel never set with a stale eu_sel.

Source files
------------

// File: rtl/aq_vpu_group1_pipe_ctrl_if.sv
// Issue/stage bus between the IDU/RTU/VFALU side and the VPU group-1 pipeline
// controller.
//
// Issue handshake: idu_vpu_ex1_inst_vld is the valid and !vpu_idu_ex1_stall is
// the ready. An issue transfers in a cycle where both are high. The ready does
// not depend on the valid, so the IDU may keep inst_vld asserted and re-present
// the same instruction until it is accepted.
interface aq_vpu_group1_pipe_ctrl_if #(
    parameter int EU_SEL_WIDTH = 10
);
    // requests and status into the controller
    logic                    idu_vpu_ex1_inst_vld;
    logic [EU_SEL_WIDTH-1:0] idu_vpu_ex1_eu_sel;
    logic                    rtu_yy_xx_flush;
    logic                    vpu_ex4_wb_stall;
    logic                    vfalu_vpu_ex1_denormal_stall;

    // controls out of the controller
    logic                    vpu_idu_ex1_stall;
    logic                    vpu_group_1_xx_ex1_sel;
    logic                    vpu_group_1_xx_ex2_sel;
    logic                    vpu_group_1_xx_ex3_sel;
    logic                    vpu_group_1_xx_ex4_sel;
    logic [EU_SEL_WIDTH-1:0] vpu_group_1_xx_ex1_eu_sel;
    logic [EU_SEL_WIDTH-1:0] vpu_group_1_xx_ex2_eu_sel;
    logic [EU_SEL_WIDTH-1:0] vpu_group_1_xx_ex3_eu_sel;
    logic [EU_SEL_WIDTH-1:0] vpu_group_1_xx_ex4_eu_sel;
    logic                    vpu_group_1_xx_ex2_stall;
    logic                    vpu_group_1_xx_ex3_stall;
    logic                    vpu_group_1_xx_ex4_stall;
    logic                    vpu_rtu_ex4_wb_vld;

    // environment side: drives requests, observes controls
    modport master (
        output idu_vpu_ex1_inst_vld, idu_vpu_ex1_eu_sel, rtu_yy_xx_flush,
               vpu_ex4_wb_stall, vfalu_vpu_ex1_denormal_stall,
        input  vpu_idu_ex1_stall,
               vpu_group_1_xx_ex1_sel, vpu_group_1_xx_ex2_sel,
               vpu_group_1_xx_ex3_sel, vpu_group_1_xx_ex4_sel,
               vpu_group_1_xx_ex1_eu_sel, vpu_group_1_xx_ex2_eu_sel,
               vpu_group_1_xx_ex3_eu_sel, vpu_group_1_xx_ex4_eu_sel,
               vpu_group_1_xx_ex2_stall, vpu_group_1_xx_ex3_stall,
               vpu_group_1_xx_ex4_stall, vpu_rtu_ex4_wb_vld
    );

    // controller side
    modport slave (
        input  idu_vpu_ex1_inst_vld, idu_vpu_ex1_eu_sel, rtu_yy_xx_flush,
               vpu_ex4_wb_stall, vfalu_vpu_ex1_denormal_stall,
        output vpu_idu_ex1_stall,
               vpu_group_1_xx_ex1_sel, vpu_group_1_xx_ex2_sel,
               vpu_group_1_xx_ex3_sel, vpu_group_1_xx_ex4_sel,
               vpu_group_1_xx_ex1_eu_sel, vpu_group_1_xx_ex2_eu_sel,
               vpu_group_1_xx_ex3_eu_sel, vpu_group_1_xx_ex4_eu_sel,
               vpu_group_1_xx_ex2_stall, vpu_group_1_xx_ex3_stall,
               vpu_group_1_xx_ex4_stall, vpu_rtu_ex4_wb_vld
    );
endinterface

// File: rtl/aq_vpu_group1_pipe_ctrl.sv
// VPU group-1 issue-side pipeline controller. Tracks issued instructions
// through ex1..ex4, drives per-stage sel/eu_sel/stall for the execution-unit
// ctrl blocks, merges writeback backpressure and the ex1 denormal stall, and
// gives the IDU its issue backpressure. eu_sel is carried opaquely.
module aq_vpu_group1_pipe_ctrl #(
    parameter int EU_SEL_WIDTH = 10
) (
    input logic                     forever_cpuclk,
    input logic                     cpurst_b,
    aq_vpu_group1_pipe_ctrl_if.slave bus
);

    logic                    ex1_vld, ex2_vld, ex3_vld, ex4_vld;
    logic                    ex1_vld_nxt, ex2_vld_nxt, ex3_vld_nxt, ex4_vld_nxt;
    logic [EU_SEL_WIDTH-1:0] ex1_eu_sel, ex2_eu_sel, ex3_eu_sel, ex4_eu_sel;
    logic                    ex1_load, ex2_load, ex3_load, ex4_load;

    logic                    flush;
    logic                    ex4_stall, ex3_stall, ex2_stall, ex1_hold;
    logic                    issue_stall, issue_accept;

    assign flush = bus.rtu_yy_xx_flush;

    // Stall chain: a stage only stalls if it is occupied and the stage ahead
    // of it stalls, so bubbles ahead of a blocked ex4 are squeezed out.
    assign ex4_stall = ex4_vld & bus.vpu_ex4_wb_stall;
    assign ex3_stall = ex3_vld & ex4_stall;
    assign ex2_stall = ex2_vld & ex3_stall;
    assign ex1_hold  = ex1_vld & (ex2_stall | bus.vfalu_vpu_ex1_denormal_stall);

    // Flush blocks issue in the flush cycle because ex1 is being cleared.
    assign issue_stall  = ex1_hold | flush;
    assign issue_accept = bus.idu_vpu_ex1_inst_vld & ~issue_stall;

    // Next-state valids; ex4 is committed and survives a flush, but nothing
    // enters it from ex3 during the flush cycle.
    always_comb begin
        ex4_vld_nxt = ex4_vld;
        ex3_vld_nxt = ex3_vld;
        ex2_vld_nxt = ex2_vld;
        ex1_vld_nxt = ex1_vld;
        ex4_load    = 1'b0;
        ex3_load    = 1'b0;
        ex2_load    = 1'b0;
        ex1_load    = 1'b0;

        if (!ex4_stall) begin
            ex4_vld_nxt = ex3_vld & ~flush;
            ex4_load    = ex3_vld & ~flush;
        end

        if (flush) begin
            ex3_vld_nxt = 1'b0;
            ex2_vld_nxt = 1'b0;
            ex1_vld_nxt = 1'b0;
        end else begin
            if (!ex3_stall) begin
                ex3_vld_nxt = ex2_vld;
                ex3_load    = ex2_vld;
            end
            // A denormal hold in ex1 sends a bubble into ex2.
            if (!ex2_stall) begin
                ex2_vld_nxt = ex1_vld & ~ex1_hold;
                ex2_load    = ex1_vld & ~ex1_hold;
            end
            if (!ex1_hold) begin
                ex1_vld_nxt = issue_accept;
                ex1_load    = issue_accept;
            end
        end
    end

    // Stage valid registers.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex1_vld <= 1'b0;
            ex2_vld <= 1'b0;
            ex3_vld <= 1'b0;
            ex4_vld <= 1'b0;
        end else begin
            ex1_vld <= ex1_vld_nxt;
            ex2_vld <= ex2_vld_nxt;
            ex3_vld <= ex3_vld_nxt;
            ex4_vld <= ex4_vld_nxt;
        end
    end

    // eu_sel registers only move with a valid instruction; stale otherwise.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex1_eu_sel <= '0;
            ex2_eu_sel <= '0;
            ex3_eu_sel <= '0;
            ex4_eu_sel <= '0;
        end else begin
            if (ex1_load) ex1_eu_sel <= bus.idu_vpu_ex1_eu_sel;
            if (ex2_load) ex2_eu_sel <= ex1_eu_sel;
            if (ex3_load) ex3_eu_sel <= ex2_eu_sel;
            if (ex4_load) ex4_eu_sel <= ex3_eu_sel;
        end
    end

    // Output drive.
    always_comb begin
        bus.vpu_idu_ex1_stall         = issue_stall;
        bus.vpu_group_1_xx_ex1_sel    = ex1_vld;
        bus.vpu_group_1_xx_ex2_sel    = ex2_vld;
        bus.vpu_group_1_xx_ex3_sel    = ex3_vld;
        bus.vpu_group_1_xx_ex4_sel    = ex4_vld;
        bus.vpu_group_1_xx_ex1_eu_sel = ex1_eu_sel;
        bus.vpu_group_1_xx_ex2_eu_sel = ex2_eu_sel;
        bus.vpu_group_1_xx_ex3_eu_sel = ex3_eu_sel;
        bus.vpu_group_1_xx_ex4_eu_sel = ex4_eu_sel;
        bus.vpu_group_1_xx_ex2_stall  = ex2_stall;
        bus.vpu_group_1_xx_ex3_stall  = ex3_stall;
        bus.vpu_group_1_xx_ex4_stall  = ex4_stall;
        bus.vpu_rtu_ex4_wb_vld        = ex4_vld & ~bus.vpu_ex4_wb_stall;
    end

endmodule

// File: tb/tb_aq_vpu_group1_pipe_ctrl.sv
// Bench for the VPU group-1 pipeline controller: directed vector table,
// hand-written reset sequence, and a random soak against a slot/queue model.
module tb_aq_vpu_group1_pipe_ctrl;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    aq_vpu_group1_pipe_ctrl_if #(.EU_SEL_WIDTH(W)) bus();

    aq_vpu_group1_pipe_ctrl #(.EU_SEL_WIDTH(W)) dut (
        .forever_cpuclk(clk),
        .cpurst_b      (rst_n),
        .bus           (bus.slave)
    );

    // clock
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic          iv;
        logic [W-1:0]  ie;
        logic          fl;
        logic          wbs;
        logic          dn;
        logic          e_idu;
        logic [3:0]    e_sel;   // {ex4,ex3,ex2,ex1}
        logic [2:0]    e_stl;   // {ex4,ex3,ex2}
        logic          e_wb;
        logic [3:0][W-1:0] e_tag; // index 0 = ex1
    } vec_t;

    vec_t tbl[36];

    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [W-1:0] ie, input logic fl,
                                input logic wbs, input logic dn, input logic e_idu,
                                input logic [3:0] e_sel, input logic [2:0] e_stl,
                                input logic e_wb, input logic [W-1:0] t1,
                                input logic [W-1:0] t2, input logic [W-1:0] t3,
                                input logic [W-1:0] t4);
        vec_t v;
        v.iv = iv; v.ie = ie; v.fl = fl; v.wbs = wbs; v.dn = dn;
        v.e_idu = e_idu; v.e_sel = e_sel; v.e_stl = e_stl; v.e_wb = e_wb;
        v.e_tag[0] = t1; v.e_tag[1] = t2; v.e_tag[2] = t3; v.e_tag[3] = t4;
        return v;
    endfunction

    function automatic logic [8:0] ctl_outs();
        return {bus.vpu_idu_ex1_stall,
                bus.vpu_group_1_xx_ex4_sel, bus.vpu_group_1_xx_ex3_sel,
                bus.vpu_group_1_xx_ex2_sel, bus.vpu_group_1_xx_ex1_sel,
                bus.vpu_group_1_xx_ex4_stall, bus.vpu_group_1_xx_ex3_stall,
                bus.vpu_group_1_xx_ex2_stall, bus.vpu_rtu_ex4_wb_vld};
    endfunction

    function automatic logic [W-1:0] eu_at(input int s);
        case (s)
            1:       return bus.vpu_group_1_xx_ex1_eu_sel;
            2:       return bus.vpu_group_1_xx_ex2_eu_sel;
            3:       return bus.vpu_group_1_xx_ex3_eu_sel;
            default: return bus.vpu_group_1_xx_ex4_eu_sel;
        endcase
    endfunction

    function automatic logic [3:0] sel_vec();
        return {bus.vpu_group_1_xx_ex4_sel, bus.vpu_group_1_xx_ex3_sel,
                bus.vpu_group_1_xx_ex2_sel, bus.vpu_group_1_xx_ex1_sel};
    endfunction

    // driver
    task automatic drive(input logic iv, input logic [W-1:0] ie, input logic fl,
                         input logic wbs, input logic dn);
        bus.idu_vpu_ex1_inst_vld         = iv;
        bus.idu_vpu_ex1_eu_sel           = ie;
        bus.rtu_yy_xx_flush              = fl;
        bus.vpu_ex4_wb_stall             = wbs;
        bus.vfalu_vpu_ex1_denormal_stall = dn;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // reference model state: slot k holds the instruction in ex(k+1)
    bit           m_v[4];
    logic [W-1:0] m_t[4];

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // directed vectors, one row per cycle
        tbl[0]  = mk(1, 10'h041, 0,0,0, 0, 4'b0000, 3'b000, 0, 0,0,0,0);
        tbl[1]  = mk(0, 0,       0,0,0, 0, 4'b0001, 3'b000, 0, 10'h041,0,0,0);
        tbl[2]  = mk(0, 0,       0,0,0, 0, 4'b0010, 3'b000, 0, 0,10'h041,0,0);
        tbl[3]  = mk(0, 0,       0,0,0, 0, 4'b0100, 3'b000, 0, 0,0,10'h041,0);
        tbl[4]  = mk(0, 0,       0,0,0, 0, 4'b1000, 3'b000, 1, 0,0,0,10'h041);
        tbl[5]  = mk(1, 10'h101, 0,0,0, 0, 4'b0000, 3'b000, 0, 0,0,0,0);
        tbl[6]  = mk(1, 10'h102, 0,0,0, 0, 4'b0001, 3'b000, 0, 10'h101,0,0,0);
        tbl[7]  = mk(1, 10'h103, 0,0,0, 0, 4'b0011, 3'b000, 0, 10'h102,10'h101,0,0);
        tbl[8]  = mk(1, 10'h104, 0,0,0, 0, 4'b0111, 3'b000, 0, 10'h103,10'h102,10'h101,0);
        tbl[9]  = mk(0, 0,       0,1,0, 1, 4'b1111, 3'b111, 0, 10'h104,10'h103,10'h102,10'h101);
        tbl[10] = mk(0, 0,       0,1,0, 1, 4'b1111, 3'b111, 0, 10'h104,10'h103,10'h102,10'h101);
        tbl[11] = mk(0, 0,       0,0,0, 0, 4'b1111, 3'b000, 1, 10'h104,10'h103,10'h102,10'h101);
        tbl[12] = mk(0, 0,       0,0,0, 0, 4'b1110, 3'b000, 1, 0,10'h104,10'h103,10'h102);
        tbl[13] = mk(0, 0,       0,0,0, 0, 4'b1100, 3'b000, 1, 0,0,10'h104,10'h103);
        tbl[14] = mk(0, 0,       0,0,0, 0, 4'b1000, 3'b000, 1, 0,0,0,10'h104);
        tbl[15] = mk(1, 10'h201, 0,0,0, 0, 4'b0000, 3'b000, 0, 0,0,0,0);
        tbl[16] = mk(1, 10'h202, 0,0,1, 1, 4'b0001, 3'b000, 0, 10'h201,0,0,0);
        tbl[17] = mk(1, 10'h202, 0,0,0, 0, 4'b0001, 3'b000, 0, 10'h201,0,0,0);
        tbl[18] = mk(0, 0,       0,0,0, 0, 4'b0011, 3'b000, 0, 10'h202,10'h201,0,0);
        tbl[19] = mk(0, 0,       0,0,0, 0, 4'b0110, 3'b000, 0, 0,10'h202,10'h201,0);
        tbl[20] = mk(0, 0,       0,0,0, 0, 4'b1100, 3'b000, 1, 0,0,10'h202,10'h201);
        tbl[21] = mk(0, 0,       0,0,0, 0, 4'b1000, 3'b000, 1, 0,0,0,10'h202);
        tbl[22] = mk(1, 10'h301, 0,0,0, 0, 4'b0000, 3'b000, 0, 0,0,0,0);
        tbl[23] = mk(1, 10'h302, 0,0,0, 0, 4'b0001, 3'b000, 0, 10'h301,0,0,0);
        tbl[24] = mk(1, 10'h303, 0,0,0, 0, 4'b0011, 3'b000, 0, 10'h302,10'h301,0,0);
        tbl[25] = mk(1, 10'h304, 0,0,0, 0, 4'b0111, 3'b000, 0, 10'h303,10'h302,10'h301,0);
        tbl[26] = mk(0, 0,       1,1,0, 1, 4'b1111, 3'b111, 0, 10'h304,10'h303,10'h302,10'h301);
        tbl[27] = mk(0, 0,       0,1,0, 0, 4'b1000, 3'b100, 0, 0,0,0,10'h301);
        tbl[28] = mk(0, 0,       0,0,0, 0, 4'b1000, 3'b000, 1, 0,0,0,10'h301);
        tbl[29] = mk(1, 10'h311, 0,0,0, 0, 4'b0000, 3'b000, 0, 0,0,0,0);
        tbl[30] = mk(1, 10'h312, 0,0,0, 0, 4'b0001, 3'b000, 0, 10'h311,0,0,0);
        tbl[31] = mk(0, 0,       0,0,0, 0, 4'b0011, 3'b000, 0, 10'h312,10'h311,0,0);
        tbl[32] = mk(0, 0,       0,0,0, 0, 4'b0110, 3'b000, 0, 0,10'h312,10'h311,0);
        tbl[33] = mk(0, 0,       1,0,0, 1, 4'b1100, 3'b000, 1, 0,0,10'h312,10'h311);
        tbl[34] = mk(1, 10'h3ff, 0,0,1, 0, 4'b0000, 3'b000, 0, 0,0,0,0);
        tbl[35] = mk(0, 0,       0,0,0, 0, 4'b0001, 3'b000, 0, 10'h3ff,0,0,0);

        // reset state
        #1;
        check("reset ctl", 64'(ctl_outs()), 64'h0);
        check("reset eu_sel", 64'({eu_at(1), eu_at(2), eu_at(3), eu_at(4)}), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < 36; i++) begin
            next_cycle();
            drive(tbl[i].iv, tbl[i].ie, tbl[i].fl, tbl[i].wbs, tbl[i].dn);
            @(negedge clk);
            check($sformatf("row%0d ctl", i), 64'(ctl_outs()),
                  64'({tbl[i].e_idu, tbl[i].e_sel, tbl[i].e_stl, tbl[i].e_wb}));
            for (int s = 1; s <= 4; s++)
                if (tbl[i].e_sel[s-1])
                    check($sformatf("row%0d ex%0d eu_sel", i, s), 64'(eu_at(s)),
                          64'(tbl[i].e_tag[s-1]));
        end

        // asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(1'b1, 10'(10'h051 + k), 1'b0, 1'b1, 1'b0);
        end
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset ctl", 64'(ctl_outs()), 64'h0);
        check("midreset eu_sel", 64'({eu_at(1), eu_at(2), eu_at(3), eu_at(4)}), 64'h0);
        @(posedge clk);
        @(negedge clk);
        check("midreset held ctl", 64'(ctl_outs()), 64'h0);
        rst_n = 1'b1;

        // first issue after reset behaves like a fresh pipeline
        for (int k = 0; k <= 5; k++) begin
            next_cycle();
            drive(k == 0, 10'h041, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("post-reset c%0d ctl", k), 64'(ctl_outs()),
                  64'({1'b0, (k >= 1 && k <= 4) ? 4'(1 << (k - 1)) : 4'b0000,
                       3'b000, k == 4}));
            if (k >= 1 && k <= 4)
                check($sformatf("post-reset c%0d eu_sel", k), 64'(eu_at(k)), 64'h041);
        end

        // random soak against a slot model plus an in-order retire queue
        begin
            logic [W-1:0] next_tag;
            logic iv, fl, wbs, dn;
            logic st4, st3, st2, h1, idu, acc, wb;
            logic [W-1:0] front;
            for (int s = 0; s < 4; s++) begin m_v[s] = 0; m_t[s] = '0; end
            next_tag = 10'h001;
            for (int c = 0; c < 600; c++) begin
                next_cycle();
                iv  = ($urandom_range(0, 9) < 7);
                fl  = ($urandom_range(0, 19) == 0);
                wbs = ($urandom_range(0, 9) < 3);
                dn  = ($urandom_range(0, 9) < 2);
                drive(iv, next_tag, fl, wbs, dn);
                @(negedge clk);

                st4 = m_v[3] & wbs;
                st3 = m_v[2] & st4;
                st2 = m_v[1] & st3;
                h1  = m_v[0] & (st2 | dn);
                idu = h1 | fl;
                acc = iv & ~idu;
                wb  = m_v[3] & ~wbs;

                check("soak ctl", 64'(ctl_outs()),
                      64'({idu, m_v[3], m_v[2], m_v[1], m_v[0], st4, st3, st2, wb}));
                for (int s = 0; s < 4; s++)
                    if (m_v[s])
                        check($sformatf("soak ex%0d eu_sel", s + 1), 64'(eu_at(s + 1)),
                              64'(m_t[s]));
                check("soak occupancy", 64'($countones(sel_vec())), 64'(exp_q.size()));

                if (bus.vpu_rtu_ex4_wb_vld) begin
                    if (exp_q.size() == 0) begin
                        check("soak retire extra", 64'(bus.vpu_group_1_xx_ex4_eu_sel), 64'h0);
                    end else begin
                        front = exp_q.pop_front();
                        check("soak retire order", 64'(bus.vpu_group_1_xx_ex4_eu_sel),
                              64'(front));
                    end
                end

                // queue: flush keeps only a committed, still-stalled ex4 entry
                if (fl) begin
                    if (st4) begin
                        while (exp_q.size() > 1) exp_q.pop_back();
                    end else begin
                        exp_q.delete();
                    end
                end
                if (acc) exp_q.push_back(next_tag);

                // slots: advance from ex4 down, frozen stages keep content
                if (fl) begin
                    if (!st4) m_v[3] = 0;
                    m_v[0] = 0; m_v[1] = 0; m_v[2] = 0;
                end else begin
                    if (!st4) begin m_v[3] = m_v[2]; m_t[3] = m_t[2]; end
                    if (!st3) begin m_v[2] = m_v[1]; m_t[2] = m_t[1]; end
                    if (!st2) begin m_v[1] = m_v[0] & ~h1; m_t[1] = m_t[0]; end
                    if (!h1)  begin m_v[0] = acc; m_t[0] = next_tag; end
                end

                if (acc) next_tag = (next_tag == 10'h3ff) ? 10'h001 : next_tag + 10'h001;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
